edge_event_decoder: RTL



---
 rtl/edge_event_decoder_pkg.sv | 33 +++
 rtl/edge_event_decoder_sat_counter.sv | 36 +++
 rtl/edge_event_decoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/edge_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_decoder_pkg
//  Purpose  : Shared types and helpers for the edge event decoder and other
//             run-length measurement blocks.
//             - state_t  : decoder state encoding (LOW, HIGH, ERR)
//             - sat_inc  : increment that saturates at 2^width-1
//  Revision : 1.0 - initial release
// ============================================================================
package edge_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_HIGH = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned MAX_CNT_W = 32;

  // Returns min(value + 1, 2^width - 1). The 33-bit intermediate keeps the
  // limit and the sum exact even for a full 32-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [32:0] limit;
    logic [32:0] sum;
    limit = (33'd1 << width) - 33'd1;
    sum   = {1'b0, value} + 33'd1;
    return (sum > limit) ? limit[31:0] : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_decoder_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : W-bit up-counter with synchronous clear and enable that
//             saturates at 2^W-1 instead of wrapping.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset (count -> 0)
//             clr   - synchronous clear, has priority over en
//             en    - count enable
//             cnt   - current count
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import edge_event_decoder_pkg::*;
#(
  parameter int unsigned W = 16   // 1..MAX_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= W'(sat_inc(32'(cnt), W));
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_decoder
//  Purpose  : Rebuilds a level signal from single-cycle rise/down pulses,
//             reports how long each level was held, and traps illegal
//             pulse sequences in a sticky error state.
//  Ports    : clk         - clock, rising edge
//             rst_n       - asynchronous active-low reset
//             rise        - rising-edge event pulse
//             down        - falling-edge event pulse
//             clr_err     - leave ERR (level-sensitive)
//             level       - reconstructed level (registered)
//             len_valid   - one-cycle strobe, run_len/len_is_high valid
//             len_is_high - 1: a high run ended, 0: a low run ended
//             run_len     - length of the run that just ended, clk cycles
//             err         - high while in ERR
//  Revision : 1.0 - initial release
// ============================================================================
module edge_event_decoder
  import edge_event_decoder_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,   // 1..MAX_CNT_W
  parameter bit          INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise,
  input  logic             down,
  input  logic             clr_err,
  output logic             level,
  output logic             len_valid,
  output logic             len_is_high,
  output logic [CNT_W-1:0] run_len,
  output logic             err
);

  localparam state_t RESET_STATE = INIT_LEVEL ? ST_HIGH : ST_LOW;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] next_len;
  logic             accept;
  logic             illegal;
  logic             err_exit;
  logic             cnt_clr;
  logic             cnt_en;

  // Only the single pulse that flips the current level is legal; anything
  // else seen while tracking a level (including both pulses at once) is an
  // error.
  assign accept   = ((state == ST_LOW)  &&  rise && !down) ||
                    ((state == ST_HIGH) &&  down && !rise);
  assign illegal  = (state != ST_ERR) && (rise || down) && !accept;
  assign err_exit = (state == ST_ERR) && clr_err;

  // The counter restarts on every new run and is held in ERR, including
  // the cycle that enters ERR.
  assign cnt_clr  = accept || err_exit;
  assign cnt_en   = (state != ST_ERR) && !rise && !down;

  // The reported run includes the transition cycle itself.
  assign next_len = CNT_W'(sat_inc(32'(run_cnt), CNT_W));

  sat_counter #(
    .W (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (run_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      level       <= INIT_LEVEL;
      len_valid   <= 1'b0;
      len_is_high <= 1'b0;
      run_len     <= '0;
      err         <= 1'b0;
    end else begin
      len_valid <= 1'b0;
      case (state)
        ST_LOW, ST_HIGH: begin
          if (accept) begin
            state       <= (state == ST_LOW) ? ST_HIGH : ST_LOW;
            level       <= (state == ST_LOW);
            len_valid   <= 1'b1;
            len_is_high <= (state == ST_HIGH);
            run_len     <= next_len;
          end else if (illegal) begin
            // level keeps its last value while in ERR
            state <= ST_ERR;
            err   <= 1'b1;
          end
        end
        ST_ERR: begin
          if (clr_err) begin
            state <= ST_LOW;
            level <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= ST_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
